msg_dispatcher: RTL and testbench

MSG_DISPATCHER -- requirements
Module: msg_dispatcher

---
 rtl/dispatch_pkg.sv | 31 +++
 rtl/dispatch_fifo.sv | 63 ++++++
 rtl/msg_dispatcher.sv | 140 ++++++++++++++
 tb/tb_msg_dispatcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg -- definitions shared by the message dispatcher and its FIFO.
//
// Contents:
//   state_t   : dispatcher FSM encoding (IDLE / DRIVE / GAP)
//   DEST_*    : destination codes driven on Sel to the downstream 1:4 demux
//   MSG_W     : width of one queued message, {dest, data}
//   pack_msg  : builds a queued message from destination and payload
package dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] DEST_LIB    = 2'd0;
  localparam logic [1:0] DEST_FIRE   = 2'd1;
  localparam logic [1:0] DEST_SCHOOL = 2'd2;
  localparam logic [1:0] DEST_RIB    = 2'd3;

  localparam int DATA_W = 4;
  localparam int DEST_W = 2;
  localparam int MSG_W  = DEST_W + DATA_W;

  // Destination sits in the upper bits so the head entry splits as {Sel, DataIn}.
  function automatic logic [MSG_W-1:0] pack_msg(input logic [DEST_W-1:0] dest,
                                                input logic [DATA_W-1:0] data);
    return {dest, data};
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo -- message storage for msg_dispatcher.
//
// DEPTH-entry FIFO of MSG_W-bit messages (DEPTH a power of two, >= 2).
// Ports:
//   clk, reset : clock and asynchronous active-high reset (empties the FIFO)
//   push       : write push_msg at the tail (caller only pushes when not full)
//   push_msg   : message to store
//   pop        : drop the head entry (caller only pops when not empty)
//   head       : current head entry, valid whenever count != 0
//   count      : current occupancy, 0..DEPTH
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [MSG_W-1:0]       push_msg,
  input  logic                   pop,
  output logic [MSG_W-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [MSG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage array needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_msg;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop moves both pointers and leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/msg_dispatcher.sv
// msg_dispatcher -- queues {dest, data} messages and plays them out to a
// downstream 1:4 demux, holding each for HOLD_CYCLES with Enable high and
// then idling GAP_CYCLES with Enable, Sel and DataIn all low.
//
// Parameters: DEPTH (FIFO entries, power of 2, >= 2), HOLD_CYCLES (>= 1),
//             GAP_CYCLES (>= 0)
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   WrData     : message payload        WrDest  : destination code
//   WrValid    : write request          WrReady : FIFO has room (from Count only)
//   DataIn/Sel/Enable : registered demux drive
//   Busy       : FSM not idle or FIFO non-empty
//   Count      : FIFO occupancy
//   DropCount  : saturating count of refused writes
// Optional feature: define DISPATCH_DROP_CNT_EN to build the DropCount
// counter; otherwise DropCount is tied to zero.
module msg_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             WrData,
  input  logic [1:0]             WrDest,
  input  logic                   WrValid,
  output logic                   WrReady,
  output logic [3:0]             DataIn,
  output logic [1:0]             Sel,
  output logic                   Enable,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Count,
  output logic [7:0]             DropCount
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             push;
  logic             pop;
  logic [MSG_W-1:0] head;
  logic [CW-1:0]    count;

  dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_msg (pack_msg(WrDest, WrData)),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Ready looks at the registered occupancy only, so a pop on this edge
  // cannot make room for a write on the same edge.
  assign WrReady = (count < CW'(DEPTH));
  assign push    = WrValid && WrReady;
  assign Count   = count;
  assign Busy    = (state != ST_IDLE) || (count != '0);

  // The "pop rule": the head is taken whenever the FSM is ready for a new
  // message -- idle, at the last DRIVE cycle when there is no gap, or at the
  // last GAP cycle -- and the FIFO holds something.
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      case (state)
        ST_IDLE:  pop = 1'b1;
        ST_DRIVE: pop = (GAP_CYCLES == 0) && (hold_cnt == '0);
        ST_GAP:   pop = (gap_cnt == '0);
        default:  pop = 1'b0;
      endcase
    end
  end

  // Dispatcher FSM with registered demux outputs. Sel/DataIn only change on
  // the edge that loads a new message, so they are stable for the whole time
  // Enable is high; every exit from DRIVE into GAP or IDLE clears all three.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      Enable   <= 1'b0;
      DataIn   <= '0;
      Sel      <= DEST_LIB;
    end else if (pop) begin
      state    <= ST_DRIVE;
      hold_cnt <= HOLD_LOAD;
      Enable   <= 1'b1;
      Sel      <= head[MSG_W-1:DATA_W];
      DataIn   <= head[DATA_W-1:0];
    end else begin
      case (state)
        ST_DRIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            state  <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            gap_cnt <= GAP_LOAD;
            Enable <= 1'b0;
            DataIn <= '0;
            Sel    <= DEST_LIB;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_DROP_CNT_EN
  // Counts edges where a write was offered but refused; sticks at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DropCount <= '0;
    end else if (WrValid && !WrReady && (DropCount != 8'hFF)) begin
      DropCount <= DropCount + 8'd1;
    end
  end
`else
  assign DropCount = '0;
`endif

endmodule

// File: tb/tb_msg_dispatcher.sv
// tb_msg_dispatcher -- directed, self-checking bench for msg_dispatcher.
//
// Three instances share clock, reset and write payload:
//   u_a : defaults (HOLD 2, GAP 1)  single write, burst, reset mid-DRIVE
//   u_b : HOLD 1, GAP 0             back-to-back dispatch
//   u_c : HOLD 8, GAP 1             FIFO fill while stalled in DRIVE, drop
// Demux outputs are checked packed as {Enable, Sel, DataIn, Count}.
module tb_msg_dispatcher;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] wrData;
  logic [1:0] wrDest;
  logic       aValid, bValid, cValid;

  logic       aReady, bReady, cReady;
  logic [3:0] aDataIn, bDataIn, cDataIn;
  logic [1:0] aSel, bSel, cSel;
  logic       aEnable, bEnable, cEnable;
  logic       aBusy, bBusy, cBusy;
  logic [2:0] aCount, bCount, cCount;
  logic [7:0] aDrop, bDrop, cDrop;

  int vectors     = 0;
  int miscompares = 0;

`ifdef DISPATCH_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  // Expected {Enable, Sel, DataIn, Count} after each edge of the four-write burst.
  localparam logic [9:0] BURST [14] = '{
    {1'b0, 2'd0, 4'h0, 3'd1},
    {1'b1, 2'd0, 4'h1, 3'd1},
    {1'b1, 2'd0, 4'h1, 3'd2},
    {1'b0, 2'd0, 4'h0, 3'd3},
    {1'b1, 2'd1, 4'h2, 3'd2},
    {1'b1, 2'd1, 4'h2, 3'd2},
    {1'b0, 2'd0, 4'h0, 3'd2},
    {1'b1, 2'd2, 4'h3, 3'd1},
    {1'b1, 2'd2, 4'h3, 3'd1},
    {1'b0, 2'd0, 4'h0, 3'd1},
    {1'b1, 2'd3, 4'h4, 3'd0},
    {1'b1, 2'd3, 4'h4, 3'd0},
    {1'b0, 2'd0, 4'h0, 3'd0},
    {1'b0, 2'd0, 4'h0, 3'd0}
  };

  always #5 clock = ~clock;

  msg_dispatcher #(.DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) u_a (
    .clk(clock), .reset(reset), .WrData(wrData), .WrDest(wrDest), .WrValid(aValid),
    .WrReady(aReady), .DataIn(aDataIn), .Sel(aSel), .Enable(aEnable),
    .Busy(aBusy), .Count(aCount), .DropCount(aDrop)
  );

  msg_dispatcher #(.DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
    .clk(clock), .reset(reset), .WrData(wrData), .WrDest(wrDest), .WrValid(bValid),
    .WrReady(bReady), .DataIn(bDataIn), .Sel(bSel), .Enable(bEnable),
    .Busy(bBusy), .Count(bCount), .DropCount(bDrop)
  );

  msg_dispatcher #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(1)) u_c (
    .clk(clock), .reset(reset), .WrData(wrData), .WrDest(wrDest), .WrValid(cValid),
    .WrReady(cReady), .DataIn(cDataIn), .Sel(cSel), .Enable(cEnable),
    .Busy(cBusy), .Count(cCount), .DropCount(cDrop)
  );

  function automatic logic [9:0] pk(input logic e, input logic [1:0] s,
                                    input logic [3:0] d, input logic [2:0] c);
    return {e, s, d, c};
  endfunction

  // Drives the write inputs for one edge, then waits until just after it.
  task automatic applyStimulus(input logic va, input logic vb, input logic vc,
                               input logic [1:0] dest, input logic [3:0] data);
    aValid = va;
    bValid = vb;
    cValid = vc;
    wrDest = dest;
    wrData = data;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] observed,
                             input logic [9:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s disagrees with expected value", tag);
    end
  endtask

  initial begin
    reset  = 1'b1;
    aValid = 1'b0;
    bValid = 1'b0;
    cValid = 1'b0;
    wrData = 4'h0;
    wrDest = 2'd0;

    // Reset state
    #12;
    checkOutput("rst.a", pk(aEnable, aSel, aDataIn, aCount), pk(1'b0, 2'd0, 4'h0, 3'd0));
    checkOutput("rst.aBusy", 10'(aBusy), 10'd0);
    checkOutput("rst.aReady", 10'(aReady), 10'd1);
    checkOutput("rst.cDrop", 10'(cDrop), 10'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single write: dest 2, data 0xA
    $display("[TB] single write");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 4'hA);
    checkOutput("single.t0", pk(aEnable, aSel, aDataIn, aCount), pk(1'b0, 2'd0, 4'h0, 3'd1));
    checkOutput("single.busy0", 10'(aBusy), 10'd1);
    idleCycles(1);
    checkOutput("single.t1", pk(aEnable, aSel, aDataIn, aCount), pk(1'b1, 2'd2, 4'hA, 3'd0));
    idleCycles(1);
    checkOutput("single.t2", pk(aEnable, aSel, aDataIn, aCount), pk(1'b1, 2'd2, 4'hA, 3'd0));
    idleCycles(1);
    checkOutput("single.gap", pk(aEnable, aSel, aDataIn, aCount), pk(1'b0, 2'd0, 4'h0, 3'd0));
    checkOutput("single.gapBusy", 10'(aBusy), 10'd1);
    idleCycles(1);
    checkOutput("single.idleBusy", 10'(aBusy), 10'd0);

    // Four back-to-back writes, also wraps the FIFO pointers
    $display("[TB] burst of four");
    for (int i = 0; i < 14; i++) begin
      if (i < 4) applyStimulus(1'b1, 1'b0, 1'b0, 2'(i), 4'(i + 1));
      else       applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
      checkOutput($sformatf("burst.%0d", i), pk(aEnable, aSel, aDataIn, aCount), BURST[i]);
      checkOutput($sformatf("burst.ready%0d", i), 10'(aReady), 10'd1);
    end
    checkOutput("burst.busyEnd", 10'(aBusy), 10'd0);

    // Fill the FIFO while u_c sits in a long DRIVE; the sixth write is refused
    $display("[TB] fill and drop");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'(i % 4), 4'(i + 1));
      if (i == 4) begin
        checkOutput("full.count", 10'(cCount), 10'd4);
        checkOutput("full.ready", 10'(cReady), 10'd0);
      end
    end
    checkOutput("drop.count", 10'(cCount), 10'd4);
    checkOutput("drop.ready", 10'(cReady), 10'd0);
    checkOutput("drop.dropCount", 10'(cDrop), 10'(EXP_DROP));
    checkOutput("drop.drive0", pk(cEnable, cSel, cDataIn, cCount), pk(1'b1, 2'd0, 4'h1, 3'd4));
    idleCycles(5);
    checkOutput("drop.drive1", pk(cEnable, cSel, cDataIn, cCount), pk(1'b1, 2'd1, 4'h2, 3'd3));
    idleCycles(27);
    checkOutput("drop.drive4", pk(cEnable, cSel, cDataIn, cCount), pk(1'b1, 2'd0, 4'h5, 3'd0));
    idleCycles(8);
    checkOutput("drop.lastGap", pk(cEnable, cSel, cDataIn, cCount), pk(1'b0, 2'd0, 4'h0, 3'd0));
    checkOutput("drop.lastGapBusy", 10'(cBusy), 10'd1);
    idleCycles(1);
    checkOutput("drop.idleBusy", 10'(cBusy), 10'd0);
    checkOutput("drop.aDropZero", 10'(aDrop), 10'd0);

    // HOLD 1 / GAP 0: three messages, Enable high three cycles in a row
    $display("[TB] zero-gap stream");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 4'h7);
    checkOutput("stream.h0", pk(bEnable, bSel, bDataIn, bCount), pk(1'b0, 2'd0, 4'h0, 3'd1));
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 4'h8);
    checkOutput("stream.h1", pk(bEnable, bSel, bDataIn, bCount), pk(1'b1, 2'd1, 4'h7, 3'd1));
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 4'h9);
    checkOutput("stream.h2", pk(bEnable, bSel, bDataIn, bCount), pk(1'b1, 2'd2, 4'h8, 3'd1));
    idleCycles(1);
    checkOutput("stream.h3", pk(bEnable, bSel, bDataIn, bCount), pk(1'b1, 2'd3, 4'h9, 3'd0));
    idleCycles(1);
    checkOutput("stream.h4", pk(bEnable, bSel, bDataIn, bCount), pk(1'b0, 2'd0, 4'h0, 3'd0));
    checkOutput("stream.busy", 10'(bBusy), 10'd0);

    // Reset in the middle of DRIVE with two messages still queued
    $display("[TB] reset mid-drive");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 4'h6);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 4'h7);
    checkOutput("midrst.before", pk(aEnable, aSel, aDataIn, aCount), pk(1'b1, 2'd1, 4'h5, 3'd2));
    aValid = 1'b0;
    reset  = 1'b1;
    #1;
    checkOutput("midrst.async", pk(aEnable, aSel, aDataIn, aCount), pk(1'b0, 2'd0, 4'h0, 3'd0));
    checkOutput("midrst.busy", 10'(aBusy), 10'd0);
    checkOutput("midrst.cDrop", 10'(cDrop), 10'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idleCycles(1);
      checkOutput($sformatf("midrst.quiet%0d", i), pk(aEnable, aSel, aDataIn, aCount),
                  pk(1'b0, 2'd0, 4'h0, 3'd0));
    end

    // First write after reset keeps the one-edge latency
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 4'hC);
    checkOutput("postrst.t0", pk(aEnable, aSel, aDataIn, aCount), pk(1'b0, 2'd0, 4'h0, 3'd1));
    idleCycles(1);
    checkOutput("postrst.t1", pk(aEnable, aSel, aDataIn, aCount), pk(1'b1, 2'd3, 4'hC, 3'd0));
    idleCycles(3);
    checkOutput("postrst.idle", 10'(aBusy), 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
